// File: rtl/crc_frame_loader.sv
// Byte-stream frame loader for the CRC driver: packs a frame big-endian into a word buffer, runs the driver, offers its CRC.
// Build option CRC_LOADER_ERR_EN: oversize frames are truncated, drained to s_last and flagged on result_err.
module crc_frame_loader #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [7:0]        len,
  output logic              crc_en,
  input  logic              crc_done,
  input  logic [15:0]       crc_in,
  output logic [15:0]       result,
  output logic              result_err,
  output logic              result_valid,
  input  logic              result_ready
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXB  = 4 * DEPTH;
  localparam int CNT_W = ADDR_W + 3;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAXB - 1);

  typedef enum logic [1:0] {FILL, DRAIN, RUN, RESULT} state_t;
  state_t state, state_nxt;

  logic [31:0]      mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic             store;

  always_ff @(posedge clk) begin
    if (!nrst) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    s_ready      = 1'b0;
    crc_en       = 1'b0;
    result_valid = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last) begin
            state_nxt = RUN;
          end else if (cnt == LAST_IDX) begin
`ifdef CRC_LOADER_ERR_EN
            state_nxt = DRAIN;
`else
            state_nxt = RUN;
`endif
          end
        end
      end
`ifdef CRC_LOADER_ERR_EN
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = RUN;
      end
`endif
      RUN: begin
        crc_en = 1'b1;
        if (crc_done) state_nxt = RESULT;
      end
      RESULT: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    if (!nrst) s_ready = 1'b0;
  end

  assign store   = (state == FILL) && s_valid;
  assign rd_data = mem[rd_addr];

`ifdef CRC_LOADER_ERR_EN
  logic trunc;
`else
  assign result_err = 1'b0;
`endif

  // Buffer write, byte count and result capture
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt    <= '0;
      len    <= '0;
      result <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef CRC_LOADER_ERR_EN
      trunc      <= 1'b0;
      result_err <= 1'b0;
`endif
    end else begin
      if (store) begin
        mem[cnt[ADDR_W+1:2]][(3 - int'(cnt[1:0])) * 8 +: 8] <= s_data;
        cnt <= cnt + CNT_W'(1);
        len <= 8'(cnt);
`ifdef CRC_LOADER_ERR_EN
        if (!s_last && cnt == LAST_IDX) trunc <= 1'b1;
`endif
      end
      if (state == RUN && crc_done) begin
        result <= crc_in;
`ifdef CRC_LOADER_ERR_EN
        result_err <= trunc;
`endif
      end
      if (state == RESULT && result_ready) begin
        cnt <= '0;
`ifdef CRC_LOADER_ERR_EN
        trunc <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_loader.sv
// Bench for crc_frame_loader: behavioural CRC-16/CCITT driver next to the DUT, scoreboard of expected results per frame.
module tb_crc_frame_loader;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              nrst;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [7:0]        len;
  logic              crc_en;
  logic              crc_done;
  logic [15:0]       crc_in;
  logic [15:0]       result;
  logic              result_err;
  logic              result_valid;
  logic              result_ready;

  always #5 clk = ~clk;

  crc_frame_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .rd_addr(rd_addr), .rd_data(rd_data), .len(len), .crc_en(crc_en),
    .crc_done(crc_done), .crc_in(crc_in), .result(result), .result_err(result_err),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Standard driver: one idle cycle on enable, then len+1 byte cycles, then done until enable drops
  int          d_st;
  int          d_idx;
  logic [15:0] d_crc;
  logic        peek;
  logic [ADDR_W-1:0] peek_addr;
  logic [7:0]  cur_byte;

  assign rd_addr  = peek ? peek_addr : ADDR_W'(d_idx >> 2);
  assign cur_byte = 8'(rd_data >> (8 * (3 - (d_idx % 4))));
  assign crc_done = (d_st == 2);
  assign crc_in   = d_crc;

  always @(posedge clk) begin
    if (!nrst) begin
      d_st  <= 0;
      d_idx <= 0;
      d_crc <= 16'hFFFF;
    end else begin
      case (d_st)
        0: if (crc_en) begin d_st <= 1; d_idx <= 0; d_crc <= 16'hFFFF; end
        1: begin
          d_crc <= crc16_byte(d_crc, cur_byte);
          d_idx <= d_idx + 1;
          if (d_idx == int'(len)) d_st <= 2;
        end
        default: if (!crc_en) d_st <= 0;
      endcase
    end
  end

  typedef struct packed {
    logic [15:0] crc;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [7:0] fb [64];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input int first, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) c = crc16_byte(c, fb[first + i]);
    return c;
  endfunction

  task automatic peek_word(input int addr, output logic [31:0] v);
    peek = 1'b1;
    peek_addr = ADDR_W'(addr);
    #1;
    v = rd_data;
    peek = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    guard   = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) check_val("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_frame(input int first, input int n, input logic last_at_end,
                           input int stored, input logic err);
    exp_t e;
    int   edges;
    e.crc = crc_of(first, stored);
    e.err = err;
    sb.push_back(e);
    for (int i = 0; i < n - 1; i++) send_byte(fb[first + i], 1'b0);
    check_val("crc_en_before_last", 32'(crc_en), 32'd0);
    send_byte(fb[first + n - 1], last_at_end);
    check_val("crc_en_rise", 32'(crc_en), 32'd1);
    edges = 0;
    while (!result_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_val("result_latency", 32'(edges), 32'(stored + 2));
    check_val("len", 32'(len), 32'(stored - 1));
  endtask

  task automatic finish_result(input int hold);
    logic [15:0] r0;
    exp_t        e;
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hEE;
      s_last  = 1'b1;
      @(negedge clk);
      check_val("hold_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
      check_val("hold_result", 32'(result), 32'(r0));
      check_val("hold_valid", 32'(result_valid), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    check_val("result_valid", 32'(result_valid), 32'd1);
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val("result", 32'(result), 32'(e.crc));
      check_val("result_err", 32'(result_err), 32'(e.err));
    end
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check_val("s_ready_after_take", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    nrst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    result_ready = 1'b0; peek = 1'b0; peek_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst_crc_en", 32'(crc_en), 32'd0);
    check_val("rst_result_valid", 32'(result_valid), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_result_err", 32'(result_err), 32'd0);
    check_val("rst_len", 32'(len), 32'd0);
    for (int a = 0; a < 8; a++) begin
      peek_word(a, w);
      check_val("rst_word", w, 32'd0);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    fb[0] = 8'h31; fb[1] = 8'h32; fb[2] = 8'h33; fb[3] = 8'h34;
    run_frame(0, 4, 1'b1, 4, 1'b0);
    peek_word(0, w);
    check_val("word0_4byte", w, 32'h31323334);
    finish_result(0);

    fb[0] = 8'hA5;
    run_frame(0, 1, 1'b1, 1, 1'b0);
    peek_word(0, w);
    check_val("word0_1byte_hi", 32'(w[31:24]), 32'hA5);
    finish_result(0);

    for (int i = 0; i < 32; i++) fb[i] = 8'(i);
    run_frame(0, 32, 1'b1, 32, 1'b0);
    peek_word(7, w);
    check_val("word7_32byte", w, 32'h1C1D1E1F);
    peek_word(0, w);
    check_val("word0_32byte", w, 32'h00010203);
    finish_result(10);

    for (int i = 0; i < 40; i++) fb[i] = 8'(8'h40 + i);
`ifdef CRC_LOADER_ERR_EN
    run_frame(0, 40, 1'b1, 32, 1'b1);
    peek_word(7, w);
    check_val("word7_trunc", w, 32'h5C5D5E5F);
    peek_word(0, w);
    check_val("word0_trunc", w, 32'h40414243);
    finish_result(0);
`else
    run_frame(0, 32, 1'b0, 32, 1'b0);
    peek_word(7, w);
    check_val("word7_forced", w, 32'h5C5D5E5F);
    finish_result(0);
    run_frame(32, 8, 1'b1, 8, 1'b0);
    peek_word(0, w);
    check_val("word0_tail", w, 32'h60616263);
    peek_word(1, w);
    check_val("word1_tail", w, 32'h64656667);
    finish_result(0);
`endif

    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_byte(fb[i], i == 3);
    @(posedge clk);
    #1;
    check_val("run_before_rst", 32'(crc_en), 32'd1);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_run_crc_en", 32'(crc_en), 32'd0);
    check_val("rst_run_valid", 32'(result_valid), 32'd0);
    check_val("rst_run_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    fb[0] = 8'hDE; fb[1] = 8'hAD;
    run_frame(0, 2, 1'b1, 2, 1'b0);
    finish_result(0);

    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_frame_loader.md
# crc_frame_loader

Upstream stage of the CRC driver. Accepts a byte stream with valid/ready and a last marker, packs one frame big-endian into a small word buffer, and presents that buffer through a zero-latency read port together with the frame length. It then raises the driver's enable, captures the 16-bit CRC when the driver reports done, and offers the result downstream with a valid/ready handshake.

## Interface
- ADDR_W, 3: buffer word-address width; depth 2^ADDR_W words; max frame MAXB = 4·2^ADDR_W bytes (32 at default; must be ≤ 32).
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- s_data  in  8  stream byte.
- s_valid  in  1  byte valid.
- s_last  in  1  final byte of frame (qualified by s_valid).
- s_ready  out  1  loader accepts byte.
- rd_addr  in  ADDR_W  word address from CRC driver.
- rd_data  out  32  buffer word, combinational read of rd_addr.
- len  out  8  frame byte count minus 1, to driver length input.
- crc_en  out  1  enable to CRC driver.
- crc_done  in  1  driver done (level).
- crc_in  in  16  driver CRC value.
- result  out  16  captured CRC.
- result_err  out  1  frame was truncated (see Configuration).
- result_valid  out  1  result available.
- result_ready  in  1  downstream takes result.

## Operation
- States: FILL, DRAIN, RUN, RESULT. Reset state FILL.
- FILL: s_ready=1. On accept, byte k (0-based) is written to word k>>2, lane k[1:0] (lane 0 = bits 31:24, lane 3 = bits 7:0); byte count cnt increments.
  - s_last accepted → RUN.
  - Byte MAXB accepted without s_last → DRAIN, trunc=1.
- DRAIN: s_ready=1, bytes discarded, cnt held at MAXB; s_last accepted → RUN.
- RUN: s_ready=0, crc_en=1, buffer and len frozen. First cycle with crc_done=1: result←crc_in, result_err←trunc, → RESULT.
- RESULT: crc_en=0, result_valid=1, s_ready=0. On result_ready=1: → FILL, cnt←0, trunc←0.
- len is registered = cnt−1, updated on each accepted stored byte; bits above bit 4 are 0. A frame always has ≥1 byte.
- Unwritten lanes of a partial last word keep the previous contents; the driver never reads them, because it consumes exactly len+1 bytes.
- While in FILL, previous frame bytes beyond the new cnt are don't-care.

## Timing
- Reset values: s_ready=0 while nrst=0; crc_en=0, result_valid=0, result=0, result_err=0, len=0, all buffer words=0, cnt=0.
- Reset mid-frame or mid-RUN returns to FILL next edge and drops crc_en; the driver shares nrst.
- rd_data has 0-cycle latency from rd_addr.
- crc_en rises in the cycle after the edge accepting the last byte.
- With the standard driver (1 idle cycle, len+1 compute cycles), result_valid rises cnt+2 edges after that accepting edge.
- crc_en is low for ≥2 cycles between frames (RESULT plus ≥1 FILL cycle). The driver therefore always returns from DONE to IDLE, and re-seeds, before the next enable.
- s_valid without s_ready is ignored; s_data need not be held.
- result is stable while result_valid=1.
- Back-to-back frames: the first byte of the next frame can be accepted the cycle after the result_ready handshake.

## Configuration
- CRC_LOADER_ERR_EN defined: DRAIN state present; oversize frames truncate to MAXB bytes, drain to s_last, and report result_err=1.
- Undefined: no DRAIN state; accepting byte MAXB forces → RUN regardless of s_last. Remaining bytes of the oversize frame are treated as the next frame. result_err is tied 0.

## Test plan
- Reset, then 4-byte frame 0x31,0x32,0x33,0x34 with last → word0=0x31323334, len=3, crc_en one cycle after last; result_valid 6 edges after last; result matches the crc16 model.
- 1-byte frame 0xA5 → len=0, word0[31:24]=0xA5, result_valid 3 edges after accept.
- 32-byte frame 0x00..0x1F with last on byte 32 → word7=0x1C1D1E1F, len=31, result_err=0.
- 40-byte frame, ERR_EN defined → bytes 33–40 accepted and dropped, len=31, result_err=1. Undefined → RUN after byte 32, and bytes 33–40 form the next frame with len=7.
- result_ready held low 10 cycles → result stable, s_ready=0; s_valid pulses ignored. Release → s_ready=1 next cycle.
- nrst asserted in RUN → crc_en=0, result_valid=0 next edge. A new 2-byte frame then yields len=1 and a correct CRC.
